// File: rtl/ex_div.sv
// Multi-cycle 32-bit DIV/DIVU unit for the EX stage: one restoring radix-2 step per cycle,
// stalls the pipeline while busy and holds {remainder, quotient} for HI/LO until consumed.
module ex_div (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stall_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic        sgn, neg_a, neg_b;
    logic [31:0] rem, quo, dvsr;
    logic [63:0] result;

    logic [31:0] abs_a, abs_b;
    logic [32:0] trial, diff;
    logic [31:0] step_rem, step_quo, fin_rem, fin_quo;

    // quo starts as |dividend| and fills with quotient bits from the LSB as the
    // dividend bits are shifted out of its MSB into the partial remainder.
    always_comb begin
        abs_a    = (signed_i && dividend_i[31]) ? -dividend_i : dividend_i;
        abs_b    = (signed_i && divisor_i[31])  ? -divisor_i  : divisor_i;
        trial    = {rem, quo[31]};
        diff     = trial - {1'b0, dvsr};
        step_quo = {quo[30:0], ~diff[32]};
        step_rem = diff[32] ? trial[31:0] : diff[31:0];
        fin_quo  = (sgn && (neg_a ^ neg_b)) ? -step_quo : step_quo;
        fin_rem  = (sgn && neg_a) ? -step_rem : step_rem;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= S_IDLE;
            cnt    <= 5'd0;
            sgn    <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            rem    <= 32'd0;
            quo    <= 32'd0;
            dvsr   <= 32'd0;
            result <= 64'd0;
        end else if (annul_i) begin
            state  <= S_IDLE;
            cnt    <= 5'd0;
            result <= 64'd0;
        end else begin
            case (state)
                S_IDLE: if (start_i) begin
                    sgn    <= signed_i;
                    neg_a  <= signed_i & dividend_i[31];
                    neg_b  <= signed_i & divisor_i[31];
                    rem    <= 32'd0;
                    quo    <= abs_a;
                    dvsr   <= abs_b;
                    cnt    <= 5'd0;
                    result <= 64'd0;
                    state  <= (divisor_i == 32'd0) ? S_BYZERO : S_ON;
                end
                S_BYZERO: begin
                    result <= 64'd0;
                    state  <= S_END;
                end
                S_ON: begin
                    rem <= step_rem;
                    quo <= step_quo;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        result <= {fin_rem, fin_quo};
                        state  <= S_END;
                    end
                end
                S_END: if (!start_i) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Reset gates the IDLE stall term so every output reads 0 while reset is held.
    always_comb begin
        case (state)
            S_IDLE:   stall_o = rst_n_i & start_i & ~annul_i;
            S_BYZERO: stall_o = 1'b1;
            S_ON:     stall_o = 1'b1;
            default:  stall_o = 1'b0;
        endcase
    end

    assign ready_o  = (state == S_END);
    assign result_o = result;

endmodule

// File: tb/tb_ex_div.sv
// Bench for ex_div: directed divisions checked every cycle against an arithmetic timing/result
// model, with literal expectations pinning the model.
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst_n, start, sg, annul;
    logic [31:0] dividend, divisor;
    logic [63:0] result;
    logic        ready, stall;

    int checks = 0;
    int failures = 0;

    ex_div dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .signed_i(sg),
        .dividend_i(dividend), .divisor_i(divisor), .annul_i(annul),
        .result_o(result), .ready_o(ready), .stall_o(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: SV division truncates toward zero and % takes the dividend's sign.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint na, nb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    // Timing model: cycles left until ready, and whether the result is currently presented.
    int          m_cnt;
    logic        m_done;
    logic [63:0] m_res = 64'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else if (annul) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else if (m_done) begin
            if (!start) m_done <= 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_done <= 1'b1;
        end else if (start) begin
            m_res <= ref_div(sg, dividend, divisor);
            m_cnt <= (divisor == 32'd0) ? 1 : 32;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", {63'd0, ready}, 64'd0);
            chk("rst_stall", {63'd0, stall}, 64'd0);
            chk("rst_result", result, 64'd0);
        end else begin
            chk("ready", {63'd0, ready}, {63'd0, m_done});
            chk("stall", {63'd0, stall},
                {63'd0, m_done ? 1'b0 : (m_cnt != 0) ? 1'b1 : (start & ~annul)});
            if (m_done) chk("result", result, m_res);
        end
    end

    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, input int hold);
        int n;
        bit got;
        n = 0;
        got = 0;
        sg = s; dividend = a; divisor = b; start = 1'b1;
        while (n < 60 && !got) begin
            @(posedge clk); #1;
            n++;
            if (scramble) begin
                dividend = $urandom;
                divisor  = $urandom;
                sg       = ~sg;
            end
            if (ready) got = 1;
        end
        chk("latency", 64'(n), (b == 32'd0) ? 64'd2 : 64'd33);
        chk("final_result", result, ref_div(s, a, b));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sg = 1'b0; annul = 1'b0;
        dividend = 32'd0; divisor = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("model_100_7",    ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        chk("model_m7_2",     ref_div(1'b1, 32'hFFFFFFF9, 32'd2), {32'hFFFFFFFF, 32'hFFFFFFFD});
        chk("model_7_m2",     ref_div(1'b1, 32'd7, 32'hFFFFFFFE), {32'h00000001, 32'hFFFFFFFD});
        chk("model_max_16",   ref_div(1'b0, 32'hFFFFFFFF, 32'h10), {32'hF, 32'h0FFFFFFF});
        chk("model_by_zero",  ref_div(1'b1, 32'h12345678, 32'd0), 64'd0);
        chk("model_overflow", ref_div(1'b1, 32'h80000000, 32'hFFFFFFFF), {32'd0, 32'h80000000});

        do_div(1'b0, 32'd100, 32'd7, 1'b0, 0);
        do_div(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, 0);
        do_div(1'b1, 32'd7, 32'hFFFFFFFE, 1'b0, 0);
        do_div(1'b0, 32'hFFFFFFFF, 32'h10, 1'b1, 0);
        do_div(1'b0, 32'd1234, 32'd0, 1'b0, 0);
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0);
        do_div(1'b1, 32'h80000000, 32'd0, 1'b0, 0);
        do_div(1'b0, 32'hFFFFFFFF, 32'd1, 1'b0, 0);
        do_div(1'b1, 32'hFFFFFFFB, 32'hFFFFFFFB, 1'b0, 0);
        do_div(1'b0, 32'd3, 32'hFFFFFFFF, 1'b0, 0);

        // Annul mid-division: nothing may complete, then a fresh division runs normally.
        sg = 1'b0; dividend = 32'd5000; divisor = 32'd9; start = 1'b1;
        repeat (10) @(posedge clk);
        #1 annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0; start = 1'b0;
        chk("annul_ready", {63'd0, ready}, 64'd0);
        chk("annul_stall", {63'd0, stall}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        do_div(1'b0, 32'd5000, 32'd9, 1'b0, 0);

        // annul wins over start while idle.
        start = 1'b1; annul = 1'b1; dividend = 32'd9; divisor = 32'd3;
        repeat (3) @(posedge clk);
        #1 start = 1'b0; annul = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset mid-division.
        sg = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", {63'd0, ready}, 64'd0);
        chk("async_rst_stall", {63'd0, stall}, 64'd0);
        chk("async_rst_result", result, 64'd0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        do_div(1'b1, 32'd1000, 32'hFFFFFFFD, 1'b0, 0);

        // start held past ready, then one low cycle and a new division.
        do_div(1'b0, 32'd77, 32'd5, 1'b0, 3);
        do_div(1'b1, 32'hFFFFFF9C, 32'd7, 1'b0, 0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 32 bits.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-004 start_i  in  1  EX stage requests a DIV/DIVU; held high until the result is consumed.
REQ-005 signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with the operands.
REQ-006 dividend_i  in  32  rs value, already forwarded by the ID stage.
REQ-007 divisor_i  in  32  rt value, already forwarded by the ID stage.
REQ-008 annul_i  in  1  flush/exception cancel; aborts any division in progress.
REQ-009 result_o  out  64  {remainder[63:32], quotient[31:0]}, destined for HI/LO.
REQ-010 ready_o  out  1  result_o valid.
REQ-011 stall_o  out  1  pipeline stall request to IF/ID/EX while a division is pending.

Function
REQ-012 The FSM SHALL have the states IDLE, BYZERO, ON and END.
REQ-013 In IDLE, with start_i=1 and annul_i=0, the block SHALL latch signed_i, |dividend_i| and |divisor_i|, plus both sign bits; absolute values are used only when signed_i=1.
REQ-014 From IDLE, the next state SHALL be BYZERO if divisor_i==0, otherwise ON with the iteration counter cleared to 0.
REQ-015 In ON, the block SHALL perform one restoring radix-2 step per cycle.
REQ-016 Each step SHALL shift the {partial remainder, dividend} left by 1, trial-subtract the divisor using a 33-bit difference, and insert quotient bit 1 if the difference is non-negative, else 0.
REQ-017 The counter SHALL increment per step; after the step with counter==31, the next state SHALL be END, giving exactly 32 cycles in ON.
REQ-018 BYZERO SHALL last one cycle, load result 64'h0, and go to END.
REQ-019 On entering END from ON with signed_i=1, the quotient SHALL be negated when the operand signs differ.
REQ-020 On entering END from ON with signed_i=1, the remainder SHALL take the sign of the dividend.
REQ-021 Negation in REQ-019/REQ-020 SHALL be 32-bit wrap-around two's complement.
REQ-022 In END, ready_o SHALL be 1 and result_o valid.
REQ-023 The FSM SHALL stay in END while start_i=1 and go to IDLE when start_i=0; a new division therefore needs start_i low for at least one cycle.
REQ-024 Latency SHALL be: start accepted in cycle T gives ready_o=1 first in cycle T+33 (nonzero divisor) or T+2 (zero divisor).
REQ-025 stall_o SHALL equal start_i & ~annul_i in IDLE, 1 in BYZERO and ON, and 0 in END, so that EX advances in the cycle ready_o is seen.
REQ-026 Changes on dividend_i, divisor_i or signed_i after acceptance SHALL have no effect on the result.
REQ-027 annul_i=1 in any state SHALL force IDLE on the next edge and clear ready_o and the counter; annul_i has priority over start_i.
REQ-028 result_o SHALL hold its last value until the next accepted start, annul or reset.
REQ-029 Overflow case 0x80000000 / 0xFFFFFFFF (signed) SHALL give quotient 0x80000000 and remainder 0 with no trap.

Reset
REQ-030 While rst_n_i=0, asynchronously: state=IDLE, counter=0, result_o=64'h0, ready_o=0, stall_o=0, latched operands=0.
REQ-031 Reset asserted mid-division SHALL abandon the operation; after release, no ready_o SHALL appear until a new start_i.

Verification
REQ-032 DIVU 100 / 7, start at T -> ready_o=1 at T+33, result_o={32'd2, 32'd14}, stall_o 1 from T to T+32 and 0 at T+33.
REQ-033 DIV 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; then DIV 7 / 0xFFFFFFFE -> quotient 0xFFFFFFFD, remainder 0x00000001.
REQ-034 DIVU 0xFFFFFFFF / 0x10 -> quotient 0x0FFFFFFF, remainder 0xF; operands toggled from T+1 on -> result unchanged.
REQ-035 Any dividend / 0 -> ready_o at T+2, result_o=0; DIV 0x80000000 / 0xFFFFFFFF -> {0, 0x80000000}.
REQ-036 annul_i pulsed at T+10 -> IDLE at T+11, stall_o=0 and ready_o never asserts; a fresh start at T+12 completes at T+45.
REQ-037 rst_n_i driven low asynchronously at T+20 -> all outputs 0 immediately; a start after release completes normally.
REQ-038 start_i held high 3 cycles past ready_o -> ready_o stays 1 and no second division starts; start_i low for 1 cycle then high -> a new division is accepted.
